// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - EX-stage request and HI/LO read bundle between the pipeline and the multiply/divide unit
interface mdu_if;
    logic [3:0]  mdu_op;
    logic [1:0]  mthilo;
    logic [1:0]  mfhilo;
    logic        op_kill;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hilo_out;

    modport master (
        output mdu_op, mthilo, mfhilo, op_kill, src_a, src_b,
        input  busy, hilo_out
    );

    modport slave (
        input  mdu_op, mthilo, mfhilo, op_kill, src_a, src_b,
        output busy, hilo_out
    );
endinterface

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle MIPS multiply/divide unit owning HI/LO; MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU
module mdu_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
`endif
    localparam logic [4:0] MULT_CNT = 5'(MULT_LAT);
    localparam logic [4:0] DIV_CNT  = 5'(DIV_LAT);

    state_t      state, state_n;
    logic [4:0]  counter;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi, lo;
    logic        op_valid, is_div, start, mt_en;

    always_comb begin
        op_valid = 1'b0;
        is_div   = 1'b0;
        case (bus.mdu_op)
            OP_MULT, OP_MULTU: op_valid = 1'b1;
            OP_DIV, OP_DIVU: begin
                op_valid = 1'b1;
                is_div   = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_valid = 1'b1;
`endif
            default: ;
        endcase
    end

    // A valid op takes priority over a move in the same cycle; the move is dropped.
    assign start = (state == IDLE) && op_valid && !bus.op_kill;
    assign mt_en = (state == IDLE) && !op_valid && !bus.op_kill && !bus.mthilo[1];

    // Division works on magnitudes; signs are restored afterwards so the
    // 0x80000000 / -1 case falls out as quotient 0x80000000, remainder 0.
    logic        sdiv;
    logic [31:0] num, den, den_safe, q_mag, r_mag, quot, rem;
    assign sdiv     = (op_q == OP_DIV);
    assign num      = (sdiv && a_q[31]) ? -a_q : a_q;
    assign den      = (sdiv && b_q[31]) ? -b_q : b_q;
    assign den_safe = (den == 32'd0) ? 32'd1 : den;
    assign q_mag    = num / den_safe;
    assign r_mag    = num % den_safe;
    assign quot     = (sdiv && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    assign rem      = (sdiv && a_q[31]) ? -r_mag : r_mag;

    logic [63:0] prod_s, prod_u, result;
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    always_comb begin
        result = 64'd0;
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV, OP_DIVU: result = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem, quot};
`ifdef MDU_MADD_EN
            // HI/LO cannot change while RUN, so the current value is the start-edge base.
            OP_MADD:  result = {hi, lo} + prod_s;
            OP_MADDU: result = {hi, lo} + prod_u;
            OP_MSUB:  result = {hi, lo} - prod_s;
            OP_MSUBU: result = {hi, lo} - prod_u;
`endif
            default:  result = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (counter == 5'd1) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= 5'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (start) begin
            counter <= is_div ? DIV_CNT : MULT_CNT;
            op_q    <= bus.mdu_op;
            a_q     <= bus.src_a;
            b_q     <= bus.src_b;
        end else if (state == RUN) begin
            counter <= counter - 5'd1;
            if (counter == 5'd1) begin
                hi <= result[63:32];
                lo <= result[31:0];
            end
        end else if (mt_en) begin
            if (bus.mthilo[0]) lo <= bus.src_a;
            else               hi <= bus.src_a;
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.hilo_out = (bus.mfhilo == 2'b01) ? hi :
                          (bus.mfhilo == 2'b10) ? lo : 32'd0;
endmodule
